// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg
//   Shared definitions for the mult/div sequencer: FSM state encoding,
//   operation codes and default cycle constants.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int MULT_CYCLES_DEF = 32;
  localparam int DIV_CYCLES_DEF  = 32;
  localparam int CNT_W_DEF       = 6;

endpackage

// File: rtl/muldiv_cycle_counter.sv
// muldiv_cycle_counter
//   Loadable down-counter that saturates at zero. It is intended for any
//   multi-cycle unit that needs a fixed-length enable window.
//   Ports:
//     clk, reset  : clock and synchronous active-high reset (count -> 0)
//     load        : load load_val this cycle (takes priority over dec)
//     load_val    : value to load
//     dec         : decrement by one if the count is not already zero
//     zero        : count is zero
module muldiv_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Sequences the multi-cycle mult and div units. A start pulse in IDLE
//   latches the operation, enables the chosen unit for a fixed number of
//   cycles, writes HI/LO from that unit for one cycle, then pulses done.
//   A divide with a zero divisor is rejected in IDLE with a div0_exc pulse.
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     start, op         : request pulse and operation (0 mult, 1 div)
//     divisor_zero      : divisor operand is zero, sampled with start
//     abort             : synchronous flush back to IDLE
//     mult_en, div_en   : unit enables
//     hi_write, lo_write: HI/LO register write enables
//     hilo_sel          : result mux select (0 mult, 1 div)
//     busy, done        : activity flag and completion pulse
//     div0_exc          : divide-by-zero pulse
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | selected unit enabled, counter running down
//   WRITE | HI/LO written from the selected unit
//   DONE  | completion pulse
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  input  logic divisor_zero,
  input  logic abort,
  output logic mult_en,
  output logic div_en,
  output logic hi_write,
  output logic lo_write,
  output logic hilo_sel,
  output logic busy,
  output logic done,
  output logic div0_exc
);

  state_e state_q, state_d;
  logic   op_q, op_d;
  logic   div0_q, div0_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  muldiv_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Counter is loaded with N-1 so that RUN lasts exactly N cycles:
  // the last RUN cycle is the one in which the count reads zero.
  assign cnt_load_val = (op == OP_DIV) ? CNT_W'(DIV_CYCLES - 1)
                                       : CNT_W'(MULT_CYCLES - 1);
  assign cnt_dec      = (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    div0_d   = 1'b0;
    cnt_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // abort in the same cycle as start drops the request entirely
        if (start && !abort) begin
          if ((op == OP_DIV) && divisor_zero) begin
            div0_d = 1'b1;
          end else begin
            op_d     = op;
            cnt_load = 1'b1;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mult_en  = (state_q == ST_RUN) && (op_q == OP_MULT);
    div_en   = (state_q == ST_RUN) && (op_q == OP_DIV);
    hi_write = (state_q == ST_WRITE);
    lo_write = (state_q == ST_WRITE);
    hilo_sel = op_q;
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    div0_exc = div0_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed bench for muldiv_sequencer with N = 32 for both units.
//   Outputs are packed as {mult_en, div_en, hi_write, lo_write,
//   hilo_sel, busy, done, div0_exc} and compared at the falling edge.
//   Cycle k of a sequence is the cycle after the k-th rising edge
//   counted from the edge that samples start (k = 1 is the first RUN cycle).
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset, start, op, divisor_zero, abort;
  logic mult_en, div_en, hi_write, lo_write, hilo_sel, busy, done, div0_exc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .divisor_zero (divisor_zero),
    .abort        (abort),
    .mult_en      (mult_en),
    .div_en       (div_en),
    .hi_write     (hi_write),
    .lo_write     (lo_write),
    .hilo_sel     (hilo_sel),
    .busy         (busy),
    .done         (done),
    .div0_exc     (div0_exc)
  );

  function automatic logic [7:0] outs();
    return {mult_en, div_en, hi_write, lo_write, hilo_sel, busy, done, div0_exc};
  endfunction

  // Expected outputs for an uninterrupted sequence with N = 32.
  function automatic logic [7:0] exp_vec(logic o, int k);
    if (k >= 1 && k <= 32) return {~o, o, 2'b00, o, 1'b1, 2'b00};
    if (k == 33)           return {2'b00, 2'b11, o, 1'b1, 2'b00};
    if (k == 34)           return {4'b0000, o, 1'b1, 1'b1, 1'b0};
    return {4'b0000, o, 3'b000};
  endfunction

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Starts a sequence and checks cycles 1..36. abort_k > 0 raises abort
  // during cycle abort_k; inj_k > 0 pulses start with the other op during
  // cycle inj_k (must be ignored).
  task automatic run_seq(string name, logic o, int abort_k, int inj_k);
    logic [7:0] e;
    @(negedge clk);
    start = 1'b1; op = o; divisor_zero = 1'b0; abort = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (abort_k > 0 && k > abort_k) e = {4'b0000, o, 3'b000};
      else                            e = exp_vec(o, k);
      chk($sformatf("%s k=%0d", name, k), outs(), e);
      start = 1'b0; op = o; abort = 1'b0;
      if (k == inj_k) begin start = 1'b1; op = ~o; end
      if (k == abort_k) abort = 1'b1;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; divisor_zero = 1'b0; abort = 1'b0;

    // reset, including a start that must be ignored while reset is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", outs(), 8'h00);
    start = 1'b1;
    @(negedge clk);
    chk("reset_hold_start", outs(), 8'h00);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", outs(), 8'h00);

    // divide by zero: one div0_exc pulse, nothing else
    start = 1'b1; op = 1'b1; divisor_zero = 1'b1;
    @(negedge clk);
    start = 1'b0; divisor_zero = 1'b0;
    chk("div0 c1", outs(), 8'h01);
    @(negedge clk);
    chk("div0 c2", outs(), 8'h00);
    @(negedge clk);
    chk("div0 c3", outs(), 8'h00);

    run_seq("mult", 1'b0, 0, 0);
    run_seq("div", 1'b1, 0, 0);
    run_seq("mult_inj", 1'b0, 0, 10);
    run_seq("mult_abort_run", 1'b0, 15, 0);
    run_seq("div_after_abort", 1'b1, 0, 0);
    run_seq("mult_abort_write", 1'b0, 33, 0);

    // abort and start together in IDLE: start dropped (op_q stays MULT)
    @(negedge clk);
    start = 1'b1; op = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_start", outs(), 8'h00);
    @(negedge clk);
    chk("idle_abort_start c2", outs(), 8'h00);

    // reset (with abort) during cycle 20 of a DIV run
    start = 1'b1; op = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 19; k++) @(negedge clk);
    chk("div_pre_reset k=20", outs(), 8'h4C);
    reset = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("div_reset c1", outs(), 8'h00);
    @(negedge clk);
    reset = 1'b0; abort = 1'b0;
    chk("div_reset c2", outs(), 8'h00);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset idle %0d", k), outs(), 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
